seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider. It is the inverse datapath to the Vedic multiplier tree in the MAC/NPU unit.
- Used for normalisation and averaging after accumulation.
- Accepts one operand pair through a valid/ready handshake and produces one quotient bit per clock.
- Holds quotient and remainder until the downstream consumer takes them.

---
 rtl/seq_restoring_divider_if.sv | 26 ++
 rtl/seq_restoring_divider.sv | 103 ++++++++++
 tb/tb_seq_restoring_divider.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the iterative restoring divider.
// master = producer/consumer side, slave = divider side.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Div_by_zero;
  logic             Busy;

  modport master (
    output In_valid, Dividend, Divisor, Out_ready,
    input  In_ready, Out_valid, Quotient, Remainder, Div_by_zero, Busy
  );

  modport slave (
    input  In_valid, Dividend, Divisor, Out_ready,
    output In_ready, Out_valid, Quotient, Remainder, Div_by_zero, Busy
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, result
// held in DONE until the consumer takes it.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_restoring_divider_if.slave dif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
  } res_t;

  state_t           state_q, state_d;
  // acc_q starts as the dividend and fills with quotient bits from the LSB
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;
  res_t             res_q;

  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             q_bit;
  logic             last_step;
  logic             div_zero;

  always_comb begin
    rem_shift = {rem_q, acc_q[WIDTH-1]};
    trial     = rem_shift - {2'b00, dvs_q};
    q_bit     = ~trial[WIDTH+1];
    rem_nxt   = q_bit ? trial[WIDTH:0] : rem_shift[WIDTH:0];
    acc_nxt   = {acc_q[WIDTH-2:0], q_bit};
    last_step = (cnt_q == CW'(WIDTH - 1));
    div_zero  = (dif.Divisor == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dif.In_valid) state_d = div_zero ? DONE : CALC;
      CALC:    if (last_step)    state_d = DONE;
      DONE:    if (dif.Out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (dif.In_valid) begin
          if (div_zero) begin
            res_q.quo <= '1;
            res_q.rem <= dif.Dividend;
            res_q.dbz <= 1'b1;
          end else begin
            acc_q <= dif.Dividend;
            dvs_q <= dif.Divisor;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (last_step) begin
            res_q.quo <= acc_nxt;
            res_q.rem <= rem_nxt[WIDTH-1:0];
            res_q.dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.In_ready    = (state_q == IDLE);
  assign dif.Out_valid   = (state_q == DONE);
  assign dif.Busy        = (state_q != IDLE);
  assign dif.Quotient    = res_q.quo;
  assign dif.Remainder   = res_q.rem;
  assign dif.Div_by_zero = res_q.dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: directed vector table, backpressure/reset sequences and
// randomized operands checked against plain integer division.
module tb_seq_restoring_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) dif ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif.slave)
  );

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int hs     = 0;
  int exp_hs = 0;

  always @(posedge clk)
    if (rst_n && dif.Out_valid && dif.Out_ready) hs++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one operation, hold the result for `stall` extra cycles, then consume.
  task automatic do_op(input logic [W-1:0] n, input logic [W-1:0] d, input int stall,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input int elat, input string tag,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    bit got;
    int lat;
    q = '0; r = '0; z = 1'b0;
    @(negedge clk);
    dif.In_valid = 1'b1;
    dif.Dividend = n;
    dif.Divisor  = d;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.In_ready) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk({tag, "_in_ready_timeout"}, 0, 1);
      dif.In_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    dif.In_valid = 1'b0;
    dif.Dividend = W'($urandom);
    dif.Divisor  = W'($urandom);
    lat = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (dif.Out_valid) begin got = 1; break; end
    end
    if (!got) begin
      chk({tag, "_out_valid_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, lat, elat);
    @(negedge clk);
    q = dif.Quotient;
    r = dif.Remainder;
    z = dif.Div_by_zero;
    chk({tag, "_quotient"}, q, eq);
    chk({tag, "_remainder"}, r, er);
    chk({tag, "_div_by_zero"}, z, ez);
    chk({tag, "_in_ready_done"}, dif.In_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold_q"}, dif.Quotient, q);
      chk({tag, "_hold_r"}, dif.Remainder, r);
      chk({tag, "_hold_valid"}, dif.Out_valid, 1);
      chk({tag, "_hold_in_ready"}, dif.In_ready, 0);
    end
    dif.Out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.Out_ready = 1'b0;
    exp_hs++;
    chk({tag, "_consumed_valid"}, dif.Out_valid, 0);
    chk({tag, "_consumed_in_ready"}, dif.In_ready, 1);
    chk({tag, "_kept_q"}, dif.Quotient, q);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] q, r, eq, er, n, d;
    logic         z, ez;
    int           elat;
    bit           stale;

    vecs[0] = '{n: 8'd200, d: 8'd7,   q: 8'd28,  r: 8'd4,  z: 1'b0, lat: 8};
    vecs[1] = '{n: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0, lat: 8};
    vecs[2] = '{n: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0, lat: 8};
    vecs[3] = '{n: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0, lat: 8};
    vecs[4] = '{n: 8'd0,   d: 8'd13,  q: 8'd0,   r: 8'd0,  z: 1'b0, lat: 8};
    vecs[5] = '{n: 8'd77,  d: 8'd0,   q: 8'd255, r: 8'd77, z: 1'b1, lat: 1};
    vecs[6] = '{n: 8'd9,   d: 8'd3,   q: 8'd3,   r: 8'd0,  z: 1'b0, lat: 8};

    dif.In_valid  = 1'b0;
    dif.Out_ready = 1'b0;
    dif.Dividend  = '0;
    dif.Divisor   = '0;

    #12;
    chk("rst_quotient", dif.Quotient, 0);
    chk("rst_remainder", dif.Remainder, 0);
    chk("rst_div_by_zero", dif.Div_by_zero, 0);
    chk("rst_out_valid", dif.Out_valid, 0);
    chk("rst_busy", dif.Busy, 0);
    chk("rst_in_ready", dif.In_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].n, vecs[i].d, 0, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat,
            $sformatf("vec%0d", i), q, r, z);

    do_op(8'd100, 8'd10, 5, 8'd10, 8'd0, 1'b0, 8, "backpressure", q, r, z);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    dif.In_valid = 1'b1;
    dif.Dividend = 8'd200;
    dif.Divisor  = 8'd7;
    @(posedge clk);
    #1 dif.In_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", dif.Busy, 0);
    chk("midrst_in_ready", dif.In_ready, 1);
    chk("midrst_out_valid", dif.Out_valid, 0);
    chk("midrst_quotient", dif.Quotient, 0);
    chk("midrst_remainder", dif.Remainder, 0);
    chk("midrst_div_by_zero", dif.Div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (dif.Out_valid) stale = 1;
    end
    chk("midrst_no_stale_result", stale, 0);
    do_op(8'd50, 8'd6, 0, 8'd8, 8'd2, 1'b0, 8, "after_rst", q, r, z);

    for (int k = 0; k < 1000; k++) begin
      n = W'($urandom);
      d = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      if (d == 0) begin
        eq = '1; er = n; ez = 1'b1; elat = 1;
      end else begin
        eq = n / d; er = n % d; ez = 1'b0; elat = W;
      end
      do_op(n, d, $urandom_range(0, 3), eq, er, ez, elat, "rand", q, r, z);
      if (d != 0) begin
        chk("rand_identity", longint'(q) * longint'(d) + longint'(r), longint'(n));
        chk("rand_rem_lt_div", (r < d) ? 1 : 0, 1);
      end
    end

    repeat (2) @(negedge clk);
    chk("handshake_count", hs, exp_hs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
